imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate-generation stage between decode and execute. It takes the raw 32-bit instruction word and an immediate-mode select, then produces the XLEN-wide extended immediate, the branch/jump target (pc + imm) and an illegal-encoding flag. It supports RV32 and RV64, CSR zimm, and XLEN-dependent shift amounts. Output is buffered behind a valid/ready handshake with a 2-entry skid buffer and a synchronous flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; equals !skid_full, driven straight from a register.
- in_instr  in  32  raw instruction word.
- in_mode  in  3  immediate mode: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZCSR.
- in_pc  in  XLEN  pc of the instruction.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_tgt  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_mode  out  3  mode carried with the beat.
- out_illegal  out  1  encoding illegal for the current XLEN.

## Operation
- **I**: sext(instr[31:20]).
- **S**: sext({instr[31:25], instr[11:7]}).
- **B**: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- **J**: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- **U**: sext({instr[31:12], 12'b0}). On XLEN=64, bit 31 is replicated into [63:32].
- **SHAMT, XLEN=32**: zext(instr[24:20]). out_illegal=1 when instr[25]=1.
- **SHAMT, XLEN=64**: zext(instr[25:20]). Never illegal.
- **ZCSR**: zext(instr[19:15]).
- **NONE**: imm=0, illegal=0.
- out_tgt is computed for every mode. The adder wraps with carry-out discarded.
- **Buffer**: two entries, main (drives the outputs) and skid. Delivery is FIFO and nothing is dropped except by flush.
- **Accept**: a beat is accepted when in_valid && in_ready.
  - Main empty or popping this cycle: the beat enters main.
  - Otherwise: the beat enters skid.
- **Pop**: when out_valid && out_ready, skid (if full) moves to main; otherwise main empties.
- **Simultaneous accept and pop**:
  - Skid empty: the new beat enters main.
  - Skid full: skid moves to main and the new beat enters skid. This case cannot occur because in_ready=0 whenever skid is full.
- **Flush**: has priority over accept and pop. Both entries are cleared, and a beat presented in the same cycle is dropped.
- **Reset**: out_valid=0, skid empty, in_ready=1, out_imm=0, out_tgt=0, out_mode=0, out_illegal=0.
  - Reset mid-transfer loses all beats.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1), provided main was empty or popping.
- Throughput is 1 beat/cycle while out_ready=1.
- With out_ready=0 and main full, one more beat is absorbed into skid; in_ready falls to 0 after that edge.
- in_ready returns to 1 the cycle after the pop that frees skid, or the cycle after flush.
- Outputs are registered and hold stable while out_valid && !out_ready.
- No combinational path exists from out_ready to in_ready.

## Structure
- Mode encodings go in ctrl_encode_def.v as `IMM_MODE_*` defines, alongside the existing `EXT_CTRL_*`.
- Sub-module imm_decode: purely combinational, parametrised by XLEN. It maps (instr, mode) to (imm, illegal).
- imm_gen_pipe instantiates imm_decode, the adder and the 2-entry buffer.
- Both buffer entries store {imm, tgt, mode, illegal}.

## Test plan
- **I-type**: XLEN=32, instr 0xFFF00093, mode I, pc 0x0 -> imm 0xFFFFFFFF, tgt 0xFFFFFFFF, illegal 0, valid after 1 cycle.
- **B-type wrap**: XLEN=32, instr 0xFE000EE3, mode B, pc 0x100 -> imm 0xFFFFFFFC, tgt 0x000000FC.
- **U-type sign**: XLEN=64, instr 0x800000B7, mode U -> imm 0xFFFFFFFF80000000. Same instr at XLEN=32 -> 0x80000000.
- **SHAMT legality**: instr 0x02009093, mode SHAMT -> XLEN=32: imm 0x0, illegal 1; XLEN=64: imm 0x20, illegal 0.
- **Backpressure**: out_ready=0, push beats A, B, C back-to-back -> A and B accepted, in_ready=0 while C is held. Raise out_ready -> A, B, C delivered in order, one per cycle.
- **Flush and reset**: with both entries full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, presented beat lost. Deassert rstn mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the immediate-generation stage: mode encoding and the
// widest datapath the decoder ever builds before trimming to XLEN.
package imm_gen_pipe_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_MODE_NONE  = 3'd0,
        IMM_MODE_I     = 3'd1,
        IMM_MODE_S     = 3'd2,
        IMM_MODE_B     = 3'd3,
        IMM_MODE_U     = 3'd4,
        IMM_MODE_J     = 3'd5,
        IMM_MODE_SHAMT = 3'd6,
        IMM_MODE_ZCSR  = 3'd7
    } imm_mode_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: builds every immediate at 64 bits, then
// keeps the low XLEN bits so sign extension is correct for either width.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_mode_e       mode_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [XLEN_MAX-1:0] immWide;

    always_comb begin
        immWide   = '0;
        illegal_o = 1'b0;
        case (mode_i)
            IMM_MODE_I:     immWide = {{52{instr_i[31]}}, instr_i[31:20]};
            IMM_MODE_S:     immWide = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_MODE_B:     immWide = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                                       instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_MODE_U:     immWide = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            IMM_MODE_J:     immWide = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                       instr_i[20], instr_i[30:21], 1'b0};
            // RV32 only has 5-bit shift amounts; bit 25 set is a reserved encoding.
            IMM_MODE_SHAMT: begin
                if (XLEN == 32) begin
                    immWide   = {59'b0, instr_i[24:20]};
                    illegal_o = instr_i[25];
                end else begin
                    immWide   = {58'b0, instr_i[25:20]};
                end
            end
            IMM_MODE_ZCSR:  immWide = {59'b0, instr_i[19:15]};
            default:        immWide = '0;
        endcase
    end

    assign imm_o = immWide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate/target generation stage with a 2-entry skid buffer,
// so in_ready comes straight from a flop and never sees out_ready.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_mode,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_tgt,
    output logic [2:0]      out_mode,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        imm_mode_e       mode;
        logic            illegal;
    } beat_t;

    imm_mode_e       inMode;
    logic [XLEN-1:0] decImm;
    logic [XLEN-1:0] decTgt;
    logic            decIllegal;
    beat_t           newBeat;

    beat_t mainQ, mainD;
    beat_t skidQ, skidD;
    logic  mainValidQ, mainValidD;
    logic  skidValidQ, skidValidD;
    logic  inReadyQ;
    logic  accept;
    logic  pop;

    assign inMode = imm_mode_e'(in_mode);

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr_i   (in_instr),
        .mode_i    (inMode),
        .imm_o     (decImm),
        .illegal_o (decIllegal)
    );

    assign decTgt  = in_pc + decImm;
    assign newBeat = '{imm: decImm, tgt: decTgt, mode: inMode, illegal: decIllegal};

    assign accept = in_valid && inReadyQ;
    assign pop    = mainValidQ && out_ready;

    // Accept only happens with skid empty, so a pop never collides with a skid write.
    always_comb begin
        mainD      = mainQ;
        skidD      = skidQ;
        mainValidD = mainValidQ;
        skidValidD = skidValidQ;
        if (flush) begin
            mainValidD = 1'b0;
            skidValidD = 1'b0;
        end else begin
            if (pop) begin
                if (skidValidQ) begin
                    mainD      = skidQ;
                    mainValidD = 1'b1;
                    skidValidD = 1'b0;
                end else begin
                    mainValidD = 1'b0;
                end
            end
            if (accept) begin
                if (!mainValidQ || pop) begin
                    mainD      = newBeat;
                    mainValidD = 1'b1;
                end else begin
                    skidD      = newBeat;
                    skidValidD = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mainQ      <= '0;
            skidQ      <= '0;
            mainValidQ <= 1'b0;
            skidValidQ <= 1'b0;
            inReadyQ   <= 1'b1;
        end else begin
            mainQ      <= mainD;
            skidQ      <= skidD;
            mainValidQ <= mainValidD;
            skidValidQ <= skidValidD;
            inReadyQ   <= !skidValidD;
        end
    end

    assign in_ready    = inReadyQ;
    assign out_valid   = mainValidQ;
    assign out_imm     = mainQ.imm;
    assign out_tgt     = mainQ.tgt;
    assign out_mode    = mainQ.mode;
    assign out_illegal = mainQ.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 and an RV64 instance with identical beats and compares both
// against a queue-based reference built from the immediate encoding rules.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_mode;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        inReady32, outValid32, outIll32;
    logic [31:0] outImm32, outTgt32;
    logic [2:0]  outMode32;
    logic        inReady64, outValid64, outIll64;
    logic [63:0] outImm64, outTgt64;
    logic [2:0]  outMode64;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] tgt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        ill64;
        logic [2:0]  mode;
    } refBeat_t;

    refBeat_t refQ[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady32),
        .in_instr(in_instr), .in_mode(in_mode), .in_pc(in_pc[31:0]),
        .out_valid(outValid32), .out_ready(out_ready),
        .out_imm(outImm32), .out_tgt(outTgt32),
        .out_mode(outMode32), .out_illegal(outIll32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady64),
        .in_instr(in_instr), .in_mode(in_mode), .in_pc(in_pc),
        .out_valid(outValid64), .out_ready(out_ready),
        .out_imm(outImm64), .out_tgt(outTgt64),
        .out_mode(outMode64), .out_illegal(outIll64)
    );

    // Immediate value as a plain integer, then wrapped to the datapath width.
    function automatic logic [63:0] refImm(input logic [31:0] ins, input logic [2:0] md,
                                           input int xlen, output logic ill);
        longint v;
        ill = 1'b0;
        v   = 0;
        case (md)
            3'd1: v = longint'($signed(ins)) >>> 20;
            3'd2: v = ((longint'($signed(ins)) >>> 25) <<< 5) + longint'(ins[11:7]);
            3'd3: v = (ins[31] ? -4096 : 0) + (longint'(ins[7]) << 11)
                      + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
            3'd4: v = longint'($signed(ins & 32'hFFFFF000));
            3'd5: v = (ins[31] ? -1048576 : 0) + (longint'(ins[19:12]) << 12)
                      + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
            3'd6: begin
                if (xlen == 32) begin
                    v   = longint'(ins[24:20]);
                    ill = ins[25];
                end else begin
                    v = longint'(ins[25:20]);
                end
            end
            3'd7: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    function automatic refBeat_t makeBeat(input logic [31:0] ins, input logic [2:0] md,
                                          input logic [63:0] pc);
        refBeat_t b;
        logic [31:0] t32;
        b.mode  = md;
        b.imm32 = refImm(ins, md, 32, b.ill32);
        b.imm64 = refImm(ins, md, 64, b.ill64);
        t32     = pc[31:0] + b.imm32[31:0];
        b.tgt32 = {32'b0, t32};
        b.tgt64 = pc + b.imm64;
        return b;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic hasBeat;
        hasBeat = (refQ.size() > 0);
        checkValue("valid32", {63'b0, outValid32}, {63'b0, hasBeat});
        checkValue("valid64", {63'b0, outValid64}, {63'b0, hasBeat});
        checkValue("ready32", {63'b0, inReady32}, {63'b0, refQ.size() < 2});
        checkValue("ready64", {63'b0, inReady64}, {63'b0, refQ.size() < 2});
        if (hasBeat) begin
            checkValue("imm32",  {32'b0, outImm32}, refQ[0].imm32);
            checkValue("tgt32",  {32'b0, outTgt32}, refQ[0].tgt32);
            checkValue("ill32",  {63'b0, outIll32}, {63'b0, refQ[0].ill32});
            checkValue("mode32", {61'b0, outMode32}, {61'b0, refQ[0].mode});
            checkValue("imm64",  outImm64, refQ[0].imm64);
            checkValue("tgt64",  outTgt64, refQ[0].tgt64);
            checkValue("ill64",  {63'b0, outIll64}, {63'b0, refQ[0].ill64});
            checkValue("mode64", {61'b0, outMode64}, {61'b0, refQ[0].mode});
        end
    endtask

    // One clock: drive inputs, advance the reference across the edge, compare.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] md,
                                 input logic [63:0] pc, input logic rdy, input logic fl);
        logic accept;
        logic pop;
        in_valid  = v;
        in_instr  = ins;
        in_mode   = md;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        accept    = v && (refQ.size() < 2);
        pop       = (refQ.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (fl) begin
            refQ.delete();
        end else begin
            if (pop) void'(refQ.pop_front());
            if (accept) refQ.push_back(makeBeat(ins, md, pc));
        end
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_valid"}, {62'b0, outValid32, outValid64}, 64'd0);
        checkValue({tag, "_ready"}, {62'b0, inReady32, inReady64}, 64'd3);
        checkValue({tag, "_imm"},   outImm64 | {32'b0, outImm32}, 64'd0);
        checkValue({tag, "_tgt"},   outTgt64 | {32'b0, outTgt32}, 64'd0);
        checkValue({tag, "_mode"},  {58'b0, outMode32, outMode64}, 64'd0);
        checkValue({tag, "_ill"},   {62'b0, outIll32, outIll64}, 64'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_mode   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        #2 rstn = 1'b1;

        $display("[TB] directed immediates");
        applyStimulus(1'b1, 32'hFFF00093, 3'd1, 64'h0, 1'b1, 1'b0);
        checkValue("itype_imm", {32'b0, outImm32}, 64'hFFFFFFFF);
        checkValue("itype_tgt", {32'b0, outTgt32}, 64'hFFFFFFFF);
        checkValue("itype_ill", {63'b0, outIll32}, 64'd0);
        applyStimulus(1'b1, 32'hFE000EE3, 3'd3, 64'h100, 1'b1, 1'b0);
        checkValue("btype_imm", {32'b0, outImm32}, 64'hFFFFFFFC);
        checkValue("btype_tgt", {32'b0, outTgt32}, 64'h000000FC);
        applyStimulus(1'b1, 32'h800000B7, 3'd4, 64'h0, 1'b1, 1'b0);
        checkValue("utype_imm32", {32'b0, outImm32}, 64'h80000000);
        checkValue("utype_imm64", outImm64, 64'hFFFFFFFF80000000);
        applyStimulus(1'b1, 32'h02009093, 3'd6, 64'h0, 1'b1, 1'b0);
        checkValue("shamt_imm32", {32'b0, outImm32}, 64'h0);
        checkValue("shamt_ill32", {63'b0, outIll32}, 64'd1);
        checkValue("shamt_imm64", outImm64, 64'h20);
        checkValue("shamt_ill64", {63'b0, outIll64}, 64'd0);
        applyStimulus(1'b0, '0, 3'd0, 64'h0, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h12345093, 3'd1, 64'h1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00A12423, 3'd2, 64'h2000, 1'b0, 1'b0);
        checkValue("bp_ready_low", {63'b0, inReady32}, 64'd0);
        applyStimulus(1'b1, 32'h0040006F, 3'd5, 64'h3000, 1'b0, 1'b0);
        checkValue("bp_hold_mode", {61'b0, outMode32}, 64'd1);
        applyStimulus(1'b1, 32'h0040006F, 3'd5, 64'h3000, 1'b1, 1'b0);
        checkValue("bp_second_mode", {61'b0, outMode32}, 64'd2);
        applyStimulus(1'b1, 32'h0040006F, 3'd5, 64'h3000, 1'b1, 1'b0);
        checkValue("bp_third_mode", {61'b0, outMode32}, 64'd5);
        applyStimulus(1'b0, '0, 3'd0, 64'h0, 1'b1, 1'b0);

        $display("[TB] flush with both entries full");
        applyStimulus(1'b1, 32'hABCDE0B7, 3'd4, 64'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000C0F3, 3'd7, 64'h80, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFF00093, 3'd1, 64'hC0, 1'b1, 1'b1);
        checkValue("flush_valid", {63'b0, outValid64}, 64'd0);
        checkValue("flush_ready", {63'b0, inReady64}, 64'd1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'hFE000EE3, 3'd3, 64'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h800000B7, 3'd4, 64'h600, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        checkResetValues("midreset");
        refQ.delete();
        #1 rstn = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                          {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 24) == 0));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 3'd0, 64'h0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
